// File: rtl/axi_arp_cache.sv
// ARP engine with a CACHE_DEPTH-entry MAC cache, gratuitous ARP after reset and bounded lookup retries.
// Optional entry aging is compiled in with `define ARP_CACHE_AGING_EN.
module axi_arp_cache #(
  parameter int          DEBUG          = 1,
  parameter logic [47:0] THIS_MAC       = 48'h010203040506,
  parameter logic [31:0] THIS_IP        = 32'hc0a80602,
  parameter int          CACHE_DEPTH    = 4,
  parameter int          TIMEOUT_CYCLES = 65535,
  parameter int          MAX_RETRIES    = 3
`ifdef ARP_CACHE_AGING_EN
  ,
  parameter int          AGE_PRESCALE   = 1000000,
  parameter int          AGE_LIMIT      = 255
`endif
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        arp_rx_valid,
  output logic        arp_rx_ready,
  input  logic [15:0] arp_rx_opcode,
  input  logic [47:0] arp_rx_src_mac,
  input  logic [31:0] arp_rx_src_ip,
  input  logic [47:0] arp_rx_dst_mac,
  input  logic [31:0] arp_rx_dst_ip,
  output logic        arp_tx_req,
  input  logic        arp_tx_ack,
  output logic [15:0] arp_tx_opcode,
  output logic [47:0] arp_tx_src_mac,
  output logic [31:0] arp_tx_src_ip,
  output logic [47:0] arp_tx_dst_mac,
  output logic [31:0] arp_tx_dst_ip,
  input  logic        arp_lookup_req,
  input  logic [31:0] arp_lookup_ip,
  output logic [47:0] arp_lookup_mac,
  output logic        arp_lookup_valid,
  output logic        arp_lookup_fail
);
  localparam int          IW            = $clog2(CACHE_DEPTH);
  localparam logic [15:0] OPER_NONE     = 16'd0;
  localparam logic [15:0] OPER_REQUEST  = 16'd1;
  localparam logic [15:0] OPER_REPLY    = 16'd2;
  localparam logic [47:0] BROADCAST_MAC = 48'hffffffffffff;
  localparam logic [31:0] BROADCAST_IP  = 32'hffffffff;

  typedef enum logic [2:0] {S_RESET, S_GRATUITOUS, S_LISTEN, S_WAIT_ACK, S_WAIT_REPLY} state_t;

  state_t state, state_nxt, ret_state;

  logic [CACHE_DEPTH-1:0] ent_vld;
  logic [31:0]            ent_ip  [CACHE_DEPTH];
  logic [47:0]            ent_mac [CACHE_DEPTH];
  logic [IW-1:0]          victim;
  logic [31:0]            pending_ip;
  logic [3:0]             retries;
  logic [15:0]            timer;

  logic          match_hit, free_hit, learn_evict, learn_ok, learn_we, do_learn;
  logic [IW-1:0] match_idx, free_idx, learn_idx;
  logic          issue, start, inc_retry, timer_dec, fail_set;
  logic [15:0]   issue_op;
  logic [47:0]   issue_mac;
  logic [31:0]   issue_ip;
  state_t        issue_ret;

  assign arp_tx_src_mac = THIS_MAC;
  assign arp_tx_src_ip  = THIS_IP;

  always_comb begin
    arp_lookup_valid = 1'b0;
    arp_lookup_mac   = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (ent_vld[i] && ent_ip[i] == arp_lookup_ip) begin
        arp_lookup_valid = 1'b1;
        arp_lookup_mac   = arp_lookup_mac | ent_mac[i];
      end
    end
  end

  // Descending scan so the lowest-index free entry wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
      if (ent_vld[i] && ent_ip[i] == arp_rx_src_ip) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
      if (!ent_vld[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
    learn_idx   = match_hit ? match_idx : (free_hit ? free_idx : victim);
    learn_evict = !match_hit && !free_hit;
    learn_ok    = (arp_rx_src_ip != 32'd0) && (arp_rx_src_ip != THIS_IP);
    learn_we    = do_learn && learn_ok;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) state <= S_RESET;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_learn  = 1'b0;
    issue     = 1'b0;
    issue_op  = OPER_NONE;
    issue_mac = BROADCAST_MAC;
    issue_ip  = BROADCAST_IP;
    issue_ret = S_LISTEN;
    start     = 1'b0;
    inc_retry = 1'b0;
    timer_dec = 1'b0;
    fail_set  = 1'b0;
    case (state)
      S_RESET: state_nxt = S_GRATUITOUS;
      S_GRATUITOUS: begin
        issue     = 1'b1;
        issue_op  = OPER_REPLY;
        issue_ip  = THIS_IP;
        state_nxt = S_WAIT_ACK;
      end
      S_LISTEN: begin
        if (arp_rx_valid) begin
          if (arp_rx_opcode == OPER_REQUEST && arp_rx_dst_ip == THIS_IP &&
              (arp_rx_dst_mac == BROADCAST_MAC || arp_rx_dst_mac == THIS_MAC)) begin
            do_learn  = 1'b1;
            issue     = 1'b1;
            issue_op  = OPER_REPLY;
            issue_mac = arp_rx_src_mac;
            issue_ip  = arp_rx_src_ip;
            state_nxt = S_WAIT_ACK;
          end else if (arp_rx_opcode == OPER_REPLY) begin
            do_learn = 1'b1;
          end
        end else if (arp_lookup_req && !arp_lookup_valid) begin
          start     = 1'b1;
          issue     = 1'b1;
          issue_op  = OPER_REQUEST;
          issue_ip  = arp_lookup_ip;
          issue_ret = S_WAIT_REPLY;
          state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: if (arp_tx_ack) state_nxt = ret_state;
      S_WAIT_REPLY: begin
        do_learn = arp_rx_valid && arp_rx_opcode == OPER_REPLY;
        if (do_learn && arp_rx_src_ip == pending_ip) begin
          state_nxt = S_LISTEN;
        end else if (timer != 16'd0) begin
          timer_dec = 1'b1;
        end else if (retries < 4'(MAX_RETRIES)) begin
          inc_retry = 1'b1;
          issue     = 1'b1;
          issue_op  = OPER_REQUEST;
          issue_ip  = pending_ip;
          issue_ret = S_WAIT_REPLY;
          state_nxt = S_WAIT_ACK;
        end else begin
          fail_set  = 1'b1;
          state_nxt = S_LISTEN;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  always_comb arp_rx_ready = (state == S_LISTEN) || (state == S_WAIT_REPLY);

`ifdef ARP_CACHE_AGING_EN
  logic [31:0] age_pre;
  logic [7:0]  ent_age [CACHE_DEPTH];
  logic        age_tick;
  assign age_tick = (age_pre == 32'(AGE_PRESCALE - 1));
`endif

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      arp_tx_req      <= 1'b0;
      arp_tx_opcode   <= OPER_NONE;
      arp_tx_dst_mac  <= BROADCAST_MAC;
      arp_tx_dst_ip   <= BROADCAST_IP;
      arp_lookup_fail <= 1'b0;
      ret_state       <= S_LISTEN;
      pending_ip      <= '0;
      retries         <= '0;
      timer           <= '0;
      victim          <= '0;
      ent_vld         <= '0;
`ifdef ARP_CACHE_AGING_EN
      age_pre <= '0;
      for (int i = 0; i < CACHE_DEPTH; i++) ent_age[i] <= '0;
`endif
    end else begin
      arp_lookup_fail <= fail_set;
      if (issue) begin
        arp_tx_req     <= 1'b1;
        arp_tx_opcode  <= issue_op;
        arp_tx_dst_mac <= issue_mac;
        arp_tx_dst_ip  <= issue_ip;
        ret_state      <= issue_ret;
      end else if (state == S_WAIT_ACK && arp_tx_ack) begin
        arp_tx_req    <= 1'b0;
        arp_tx_opcode <= OPER_NONE;
        if (ret_state == S_WAIT_REPLY) timer <= 16'(TIMEOUT_CYCLES);
      end
      if (start) begin
        pending_ip <= arp_lookup_ip;
        retries    <= '0;
      end
      if (inc_retry) retries <= retries + 4'd1;
      if (timer_dec) timer <= timer - 16'd1;
      if (learn_we && learn_evict) victim <= victim + IW'(1);
`ifdef ARP_CACHE_AGING_EN
      age_pre <= age_tick ? 32'd0 : age_pre + 32'd1;
`endif
      for (int i = 0; i < CACHE_DEPTH; i++) begin
        if (learn_we && learn_idx == IW'(i)) begin
          ent_vld[i] <= 1'b1;
`ifdef ARP_CACHE_AGING_EN
          ent_age[i] <= '0;
`endif
        end
`ifdef ARP_CACHE_AGING_EN
        else if (age_tick && ent_vld[i]) begin
          if (ent_age[i] != 8'hff) ent_age[i] <= ent_age[i] + 8'd1;
          if (ent_age[i] + 8'd1 == 8'(AGE_LIMIT)) ent_vld[i] <= 1'b0;
        end
`endif
      end
    end
  end

  // Table payload needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (learn_we) begin
      ent_ip[learn_idx]  <= arp_rx_src_ip;
      ent_mac[learn_idx] <= arp_rx_src_mac;
    end
  end
endmodule

// File: tb/tb_axi_arp_cache.sv
// Directed bench for axi_arp_cache with a behavioural cache model checked on every cycle.
module tb_axi_arp_cache;
  localparam logic [47:0] MY_MAC = 48'h010203040506;
  localparam logic [31:0] MY_IP  = 32'hc0a80602;
  localparam logic [47:0] BC_MAC = 48'hffffffffffff;
  localparam logic [15:0] OP_REQ = 16'd1;
  localparam logic [15:0] OP_REP = 16'd2;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        arp_rx_valid, arp_rx_ready;
  logic [15:0] arp_rx_opcode;
  logic [47:0] arp_rx_src_mac, arp_rx_dst_mac;
  logic [31:0] arp_rx_src_ip, arp_rx_dst_ip;
  logic        arp_tx_req, arp_tx_ack;
  logic [15:0] arp_tx_opcode;
  logic [47:0] arp_tx_src_mac, arp_tx_dst_mac;
  logic [31:0] arp_tx_src_ip, arp_tx_dst_ip;
  logic        arp_lookup_req;
  logic [31:0] arp_lookup_ip;
  logic [47:0] arp_lookup_mac;
  logic        arp_lookup_valid, arp_lookup_fail;

  axi_arp_cache #(
    .DEBUG(0), .THIS_MAC(MY_MAC), .THIS_IP(MY_IP),
    .CACHE_DEPTH(4), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .arp_rx_valid(arp_rx_valid), .arp_rx_ready(arp_rx_ready),
    .arp_rx_opcode(arp_rx_opcode), .arp_rx_src_mac(arp_rx_src_mac),
    .arp_rx_src_ip(arp_rx_src_ip), .arp_rx_dst_mac(arp_rx_dst_mac),
    .arp_rx_dst_ip(arp_rx_dst_ip),
    .arp_tx_req(arp_tx_req), .arp_tx_ack(arp_tx_ack),
    .arp_tx_opcode(arp_tx_opcode), .arp_tx_src_mac(arp_tx_src_mac),
    .arp_tx_src_ip(arp_tx_src_ip), .arp_tx_dst_mac(arp_tx_dst_mac),
    .arp_tx_dst_ip(arp_tx_dst_ip),
    .arp_lookup_req(arp_lookup_req), .arp_lookup_ip(arp_lookup_ip),
    .arp_lookup_mac(arp_lookup_mac), .arp_lookup_valid(arp_lookup_valid),
    .arp_lookup_fail(arp_lookup_fail)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cache model: plain table of learned bindings with a round-robin replacement slot.
  logic        m_vld [4];
  logic [31:0] m_ip  [4];
  logic [47:0] m_mac [4];
  int          m_victim;

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
    m_victim = 0;
  endfunction

  function automatic void m_learn(input logic [31:0] ip, input logic [47:0] mac);
    if (ip == 32'd0 || ip == MY_IP) return;
    for (int i = 0; i < 4; i++)
      if (m_vld[i] && m_ip[i] == ip) begin m_mac[i] = mac; return; end
    for (int i = 0; i < 4; i++)
      if (!m_vld[i]) begin m_vld[i] = 1'b1; m_ip[i] = ip; m_mac[i] = mac; return; end
    m_ip[m_victim]  = ip;
    m_mac[m_victim] = mac;
    m_victim = (m_victim + 1) % 4;
  endfunction

  function automatic logic [48:0] m_look(input logic [31:0] ip);
    for (int i = 0; i < 4; i++)
      if (m_vld[i] && m_ip[i] == ip) return {1'b1, m_mac[i]};
    return 49'd0;
  endfunction

  bit          cmp_en = 1'b0;
  logic [48:0] cmp_exp;
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_exp = m_look(arp_lookup_ip);
      chk("lookup_valid_vs_model", arp_lookup_valid, cmp_exp[48]);
      chk("lookup_mac_vs_model", arp_lookup_mac, cmp_exp[47:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [15:0] op, input logic [47:0] smac, input logic [31:0] sip,
                         input logic [47:0] dmac, input logic [31:0] dip);
    arp_rx_valid = 1'b1; arp_rx_opcode = op;
    arp_rx_src_mac = smac; arp_rx_src_ip = sip;
    arp_rx_dst_mac = dmac; arp_rx_dst_ip = dip;
    @(negedge clk);
    chk("rx_ready", arp_rx_ready, 1);
    step();
    arp_rx_valid = 1'b0;
    if (op == OP_REP || (op == OP_REQ && dip == MY_IP && (dmac == BC_MAC || dmac == MY_MAC)))
      m_learn(sip, smac);
  endtask

  task automatic wait_req();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (arp_tx_req) break;
    end
    chk("tx_req_seen", arp_tx_req, 1);
  endtask

  task automatic expect_tx(input logic [15:0] op, input logic [47:0] mac, input logic [31:0] ip,
                           input int hold);
    wait_req();
    chk("tx_opcode", arp_tx_opcode, op);
    chk("tx_dst_mac", arp_tx_dst_mac, mac);
    chk("tx_dst_ip", arp_tx_dst_ip, ip);
    chk("tx_src_mac", arp_tx_src_mac, MY_MAC);
    chk("tx_src_ip", arp_tx_src_ip, MY_IP);
    repeat (hold) begin
      @(negedge clk);
      chk("tx_req_held", arp_tx_req, 1);
      chk("tx_opcode_held", arp_tx_opcode, op);
    end
    arp_tx_ack = 1'b1;
    step();
    arp_tx_ack = 1'b0;
    @(negedge clk);
    chk("tx_req_drop", arp_tx_req, 0);
    chk("tx_opcode_none", arp_tx_opcode, 0);
    step();
  endtask

  task automatic quiet(input string name, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      chk(name, arp_tx_req, 0);
    end
    step();
  endtask

  task automatic look(input string name, input logic [31:0] ip, input logic vld, input logic [47:0] mac);
    arp_lookup_ip = ip;
    @(negedge clk);
    chk({name, "_valid"}, arp_lookup_valid, vld);
    chk({name, "_mac"}, arp_lookup_mac, mac);
    step();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    m_clear();
    step();
    step();
    aresetn = 1'b1;
    expect_tx(OP_REP, BC_MAC, MY_IP, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int extra;
    aresetn = 1'b0; arp_rx_valid = 1'b0; arp_rx_opcode = '0;
    arp_rx_src_mac = '0; arp_rx_src_ip = '0; arp_rx_dst_mac = '0; arp_rx_dst_ip = '0;
    arp_tx_ack = 1'b0; arp_lookup_req = 1'b0; arp_lookup_ip = 32'hc0a80601;
    m_clear();
    repeat (3) step();
    cmp_en = 1'b1;

    @(negedge clk);
    chk("rst_tx_req", arp_tx_req, 0);
    chk("rst_tx_opcode", arp_tx_opcode, 0);
    chk("rst_tx_dst_mac", arp_tx_dst_mac, BC_MAC);
    chk("rst_tx_dst_ip", arp_tx_dst_ip, 32'hffffffff);
    chk("rst_lookup_fail", arp_lookup_fail, 0);
    chk("rst_rx_ready", arp_rx_ready, 0);
    step();
    aresetn = 1'b1;

    // Gratuitous reply, acked after two held cycles.
    expect_tx(OP_REP, BC_MAC, MY_IP, 2);
    @(negedge clk);
    chk("listen_rx_ready", arp_rx_ready, 1);
    step();

    // Request for us: learn sender, reply to it.
    send_rx(OP_REQ, 48'h020000000001, 32'hc0a80601, BC_MAC, MY_IP);
    expect_tx(OP_REP, 48'h020000000001, 32'hc0a80601, 1);
    look("hit_01", 32'hc0a80601, 1'b1, 48'h020000000001);

    // Unanswered lookup: three requests then one fail pulse.
    arp_lookup_ip = 32'hc0a80605;
    arp_lookup_req = 1'b1;
    expect_tx(OP_REQ, BC_MAC, 32'hc0a80605, 0);
    arp_lookup_req = 1'b0;
    expect_tx(OP_REQ, BC_MAC, 32'hc0a80605, 0);
    expect_tx(OP_REQ, BC_MAC, 32'hc0a80605, 0);
    extra = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (arp_tx_req) extra++;
      if (arp_lookup_fail) break;
    end
    chk("fail_pulse", arp_lookup_fail, 1);
    chk("no_fourth_request", extra, 0);
    @(negedge clk);
    chk("fail_one_cycle", arp_lookup_fail, 0);
    chk("fail_back_listen", arp_rx_ready, 1);
    quiet("no_retx_after_fail", 10);

    // Eviction and in-place update on a clean table.
    do_reset();
    for (int k = 0; k < 5; k++)
      send_rx(OP_REP, 48'h020000000010 + 48'(k), 32'hc0a8060a + 32'(k), MY_MAC, MY_IP);
    look("evicted_0a", 32'hc0a8060a, 1'b0, 48'h0);
    look("stored_0e", 32'hc0a8060e, 1'b1, 48'h020000000014);
    send_rx(OP_REP, 48'h0200000000bb, 32'hc0a8060b, MY_MAC, MY_IP);
    look("update_0b", 32'hc0a8060b, 1'b1, 48'h0200000000bb);
    look("kept_0d", 32'hc0a8060d, 1'b1, 48'h020000000013);
    send_rx(OP_REP, 48'h0200000000ee, 32'h0, MY_MAC, MY_IP);
    send_rx(OP_REP, 48'h0200000000ef, MY_IP, MY_MAC, MY_IP);
    look("never_self", MY_IP, 1'b0, 48'h0);
    send_rx(OP_REQ, 48'h020000000020, 32'hc0a80614, BC_MAC, 32'hc0a80663);
    quiet("foreign_req_dropped", 3);
    look("foreign_not_learned", 32'hc0a80614, 1'b0, 48'h0);
    send_rx(OP_REP, 48'h02000000001f, 32'hc0a8060f, MY_MAC, MY_IP);
    look("victim_after_update", 32'hc0a8060b, 1'b0, 48'h0);
    look("kept_0c", 32'hc0a8060c, 1'b1, 48'h020000000012);

    // rx and lookup together: reply first, then the request, then its reply.
    arp_lookup_ip = 32'hc0a80628;
    arp_lookup_req = 1'b1;
    send_rx(OP_REQ, 48'h02000000001e, 32'hc0a8061e, MY_MAC, MY_IP);
    expect_tx(OP_REP, 48'h02000000001e, 32'hc0a8061e, 0);
    expect_tx(OP_REQ, BC_MAC, 32'hc0a80628, 0);
    arp_lookup_req = 1'b0;
    send_rx(OP_REP, 48'h020000000028, 32'hc0a80628, MY_MAC, MY_IP);
    quiet("no_retry_after_reply", 15);
    look("resolved_28", 32'hc0a80628, 1'b1, 48'h020000000028);

    // Reset while a request waits for its ack.
    arp_lookup_ip = 32'hc0a80632;
    arp_lookup_req = 1'b1;
    wait_req();
    aresetn = 1'b0;
    arp_lookup_req = 1'b0;
    step();
    m_clear();
    arp_lookup_ip = 32'hc0a80628;
    @(negedge clk);
    chk("midrst_tx_req", arp_tx_req, 0);
    chk("midrst_tx_opcode", arp_tx_opcode, 0);
    chk("midrst_cache_clear", arp_lookup_valid, 0);
    step();
    aresetn = 1'b1;
    expect_tx(OP_REP, BC_MAC, MY_IP, 0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
